ysyx_24080006_axi_arbiter: RTL and testbench

//  Shares one AXI4 memory port between the IFU (read-only) and the LSU (read/write).

---
 rtl/ysyx_24080006_axi_pkg.sv | 47 ++++
 rtl/ysyx_24080006_axi_arbiter.sv | 136 +++++++++++++
 tb/tb_ysyx_24080006_axi_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24080006_axi_pkg.sv
// AXI4 channel bundles shared by the arbiter and its masters/slave.
// Read bundles carry AR+R, write bundles carry AW+W+B, split by direction.
// Widths: 32-bit address/data, 4-bit IDs.
package ysyx_24080006_axi_pkg;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;
    logic [3:0]  rid;
  } axi_r_s2m_t;

  typedef struct packed {
    logic        awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
  } axi_w_m2s_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
  } axi_w_s2m_t;

endpackage

// File: rtl/ysyx_24080006_axi_arbiter.sv
// Shares one AXI4 memory port between the IFU (read-only) and the LSU (read/write).
// Latency: +1 cycle on AR/AW acceptance (registered grant); R/W/B data paths are combinational.
// Backpressure: a non-granted master sees ready=0 and is stalled; the granted path passes ready/valid untouched.
module ysyx_24080006_axi_arbiter
  import ysyx_24080006_axi_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  axi_r_m2s_t ifu_r_m2s,
  output axi_r_s2m_t ifu_r_s2m,
  input  axi_r_m2s_t lsu_r_m2s,
  output axi_r_s2m_t lsu_r_s2m,
  input  axi_w_m2s_t lsu_w_m2s,
  output axi_w_s2m_t lsu_w_s2m,
  output axi_r_m2s_t mem_r_m2s,
  input  axi_r_s2m_t mem_r_s2m,
  output axi_w_m2s_t mem_w_m2s,
  input  axi_w_s2m_t mem_w_s2m,
  output logic       arb_busy,
  output logic [1:0] arb_grant
);

  // State encoding doubles as the grant code seen on arb_grant.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RD_IFU = 2'b01,
    RD_LSU = 2'b10,
    WR_LSU = 2'b11
  } state_t;

  typedef enum logic {
    WIN_IFU = 1'b0,
    WIN_LSU = 1'b1
  } winner_t;

  state_t  state_q, state_d;
  winner_t last_winner_q, last_winner_d;

  logic req_ifu;
  logic req_lsu_rd;
  logic req_lsu_wr;
  logic req_lsu;
  logic lsu_wins_tie;
  logic rd_rready;
  logic rd_done;
  logic wr_done;

  // Request decode and transaction-completion detection.
  always_comb begin
    req_ifu    = ifu_r_m2s.arvalid;
    req_lsu_rd = lsu_r_m2s.arvalid;
    req_lsu_wr = lsu_w_m2s.awvalid | lsu_w_m2s.wvalid;
    req_lsu    = req_lsu_rd | req_lsu_wr;
    // Round-robin hands a contested slot to whoever did not win last time.
    lsu_wins_tie = RR_EN ? (last_winner_q == WIN_IFU) : 1'b1;
    rd_rready = 1'b0;
    if (state_q == RD_IFU) begin
      rd_rready = ifu_r_m2s.rready;
    end else if (state_q == RD_LSU) begin
      rd_rready = lsu_r_m2s.rready;
    end
    rd_done = mem_r_s2m.rvalid & rd_rready & mem_r_s2m.rlast;
    wr_done = mem_w_s2m.bvalid & lsu_w_m2s.bready;
  end

  // State and last-winner registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_winner_q <= WIN_IFU;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
    end
  end

  // Next-state: arbitrate only from IDLE, hold the grant until the last R beat or B.
  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    case (state_q)
      IDLE: begin
        if (req_lsu && (!req_ifu || lsu_wins_tie)) begin
          // The LSU never raises read and write together; write takes precedence anyway.
          state_d       = req_lsu_wr ? WR_LSU : RD_LSU;
          last_winner_d = WIN_LSU;
        end else if (req_ifu) begin
          state_d       = RD_IFU;
          last_winner_d = WIN_IFU;
        end
      end
      RD_IFU, RD_LSU: begin
        if (rd_done) begin
          state_d = IDLE;
        end
      end
      WR_LSU: begin
        if (wr_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel steering: only the granted path is connected, everything else reads as zero.
  always_comb begin
    ifu_r_s2m = '0;
    lsu_r_s2m = '0;
    lsu_w_s2m = '0;
    mem_r_m2s = '0;
    mem_w_m2s = '0;
    case (state_q)
      RD_IFU: begin
        mem_r_m2s = ifu_r_m2s;
        ifu_r_s2m = mem_r_s2m;
      end
      RD_LSU: begin
        mem_r_m2s = lsu_r_m2s;
        lsu_r_s2m = mem_r_s2m;
      end
      WR_LSU: begin
        mem_w_m2s = lsu_w_m2s;
        lsu_w_s2m = mem_w_s2m;
      end
      default: begin
      end
    endcase
  end

  assign arb_busy  = (state_q != IDLE);
  assign arb_grant = state_q;

endmodule

// File: tb/tb_ysyx_24080006_axi_arbiter.sv
// Scoreboard bench for the IFU/LSU AXI arbiter: two instances (round-robin and fixed priority)
// share stimulus and a reactive slave; the selected instance's outputs are checked.
// Expected grants, read beats, AW/W/B traffic are queued by stimulus and popped by the monitor.
module tb_ysyx_24080006_axi_arbiter;
  import ysyx_24080006_axi_pkg::*;

  typedef struct packed { logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; } wbeat_t;

  logic clock, reset, sel_fp;
  axi_r_m2s_t ifu_r_m2s, lsu_r_m2s;
  axi_w_m2s_t lsu_w_m2s;
  axi_r_s2m_t mem_r_s2m;
  axi_w_s2m_t mem_w_s2m;

  axi_r_s2m_t rr_ifu_r_s2m, rr_lsu_r_s2m, fp_ifu_r_s2m, fp_lsu_r_s2m;
  axi_w_s2m_t rr_lsu_w_s2m, fp_lsu_w_s2m;
  axi_r_m2s_t rr_mem_r_m2s, fp_mem_r_m2s;
  axi_w_m2s_t rr_mem_w_m2s, fp_mem_w_m2s;
  logic       rr_busy, fp_busy;
  logic [1:0] rr_grant, fp_grant;

  axi_r_s2m_t ifu_r_s2m, lsu_r_s2m;
  axi_w_s2m_t lsu_w_s2m;
  axi_r_m2s_t mem_r_m2s;
  axi_w_m2s_t mem_w_m2s;
  logic       arb_busy;
  logic [1:0] arb_grant;

  assign ifu_r_s2m = sel_fp ? fp_ifu_r_s2m : rr_ifu_r_s2m;
  assign lsu_r_s2m = sel_fp ? fp_lsu_r_s2m : rr_lsu_r_s2m;
  assign lsu_w_s2m = sel_fp ? fp_lsu_w_s2m : rr_lsu_w_s2m;
  assign mem_r_m2s = sel_fp ? fp_mem_r_m2s : rr_mem_r_m2s;
  assign mem_w_m2s = sel_fp ? fp_mem_w_m2s : rr_mem_w_m2s;
  assign arb_busy  = sel_fp ? fp_busy : rr_busy;
  assign arb_grant = sel_fp ? fp_grant : rr_grant;

  ysyx_24080006_axi_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clock(clock), .reset(reset),
    .ifu_r_m2s(ifu_r_m2s), .ifu_r_s2m(rr_ifu_r_s2m),
    .lsu_r_m2s(lsu_r_m2s), .lsu_r_s2m(rr_lsu_r_s2m),
    .lsu_w_m2s(lsu_w_m2s), .lsu_w_s2m(rr_lsu_w_s2m),
    .mem_r_m2s(rr_mem_r_m2s), .mem_r_s2m(mem_r_s2m),
    .mem_w_m2s(rr_mem_w_m2s), .mem_w_s2m(mem_w_s2m),
    .arb_busy(rr_busy), .arb_grant(rr_grant)
  );

  ysyx_24080006_axi_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clock(clock), .reset(reset),
    .ifu_r_m2s(ifu_r_m2s), .ifu_r_s2m(fp_ifu_r_s2m),
    .lsu_r_m2s(lsu_r_m2s), .lsu_r_s2m(fp_lsu_r_s2m),
    .lsu_w_m2s(lsu_w_m2s), .lsu_w_s2m(fp_lsu_w_s2m),
    .mem_r_m2s(fp_mem_r_m2s), .mem_r_s2m(mem_r_s2m),
    .mem_w_m2s(fp_mem_w_m2s), .mem_w_s2m(mem_w_s2m),
    .arb_busy(fp_busy), .arb_grant(fp_grant)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;
  int ifu_beats = 0;
  int last_gap = 0;
  int t6_base = 0;

  logic [1:0] grant_q[$];
  rbeat_t     ifu_q[$];
  rbeat_t     lsu_q[$];
  logic [31:0] aw_q[$];
  wbeat_t     w_q[$];
  logic [1:0] b_q[$];

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] vr_vec();
    return {ifu_r_s2m.arready, ifu_r_s2m.rvalid, lsu_r_s2m.arready, lsu_r_s2m.rvalid,
            lsu_w_s2m.awready, lsu_w_s2m.wready, lsu_w_s2m.bvalid,
            mem_r_m2s.arvalid, mem_r_m2s.rready, mem_w_m2s.awvalid, mem_w_m2s.wvalid,
            mem_w_m2s.bready, arb_busy, arb_grant};
  endfunction

  function automatic logic [31:0] slave_data(input logic [31:0] a, input logic [7:0] b);
    return (a == 32'h3000_0000) ? 32'hDEADBEEF : a + {22'd0, b, 2'b00};
  endfunction

  // Reactive slave: AR accepted when idle, beats back-to-back; AW before W, B three cycles after W.
  logic        s_rd_act;
  logic [31:0] s_addr, s_cap_addr;
  logic [7:0]  s_len, s_beat, s_cap_len;
  int          s_wst, s_cnt;
  logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;

  task automatic present_beat();
    mem_r_s2m.rvalid = 1'b1;
    mem_r_s2m.rdata  = slave_data(s_addr, s_beat);
    mem_r_s2m.rlast  = (s_beat == s_len);
    mem_r_s2m.rresp  = (s_addr[31:28] == 4'h8) ? 2'b01 : 2'b00;
    mem_r_s2m.rid    = 4'd0;
  endtask

  initial begin
    mem_r_s2m = '0; mem_w_s2m = '0;
    s_rd_act = 1'b0; s_addr = '0; s_len = '0; s_beat = '0; s_wst = 0; s_cnt = 0;
    forever begin
      @(negedge clock);
      ar_hs = mem_r_m2s.arvalid & mem_r_s2m.arready;
      r_hs  = mem_r_s2m.rvalid & mem_r_m2s.rready;
      aw_hs = mem_w_m2s.awvalid & mem_w_s2m.awready;
      w_hs  = mem_w_m2s.wvalid & mem_w_s2m.wready;
      b_hs  = mem_w_s2m.bvalid & mem_w_m2s.bready;
      s_cap_addr = mem_r_m2s.araddr;
      s_cap_len  = mem_r_m2s.arlen;
      @(posedge clock);
      #2;
      if (!reset) begin
        mem_r_s2m = '0; mem_w_s2m = '0; s_rd_act = 1'b0; s_wst = 0;
      end else begin
        if (!s_rd_act) begin
          mem_r_s2m.arready = 1'b1;
          if (ar_hs) begin
            s_rd_act = 1'b1; s_addr = s_cap_addr; s_len = s_cap_len; s_beat = 8'd0;
            mem_r_s2m.arready = 1'b0;
            present_beat();
          end
        end else if (r_hs) begin
          if (mem_r_s2m.rlast) begin
            mem_r_s2m.rvalid = 1'b0; mem_r_s2m.rlast = 1'b0;
            s_rd_act = 1'b0; mem_r_s2m.arready = 1'b1;
          end else begin
            s_beat = s_beat + 8'd1;
            present_beat();
          end
        end
        case (s_wst)
          0: begin
            mem_w_s2m.awready = 1'b1;
            if (aw_hs) begin mem_w_s2m.awready = 1'b0; mem_w_s2m.wready = 1'b1; s_wst = 1; end
          end
          1: if (w_hs) begin mem_w_s2m.wready = 1'b0; s_cnt = 0; s_wst = 2; end
          2: begin
            s_cnt++;
            if (s_cnt == 2) begin mem_w_s2m.bvalid = 1'b1; mem_w_s2m.bresp = 2'b01; s_wst = 3; end
          end
          default: if (b_hs) begin mem_w_s2m.bvalid = 1'b0; mem_w_s2m.awready = 1'b1; s_wst = 0; end
        endcase
      end
    end
  end

  // Read master (IFU or LSU): issue AR, hold it until accepted, finish on the last R beat.
  task automatic rd_master(input logic lsu, input logic [31:0] addr, input logic [7:0] len);
    axi_r_m2s_t m;
    axi_r_s2m_t s;
    logic got_ar, done;
    int n;
    m = '0; m.arvalid = 1'b1; m.araddr = addr; m.arlen = len;
    m.arsize = 3'b010; m.arburst = 2'b01; m.rready = 1'b1;
    if (lsu) lsu_r_m2s = m; else ifu_r_m2s = m;
    got_ar = 1'b0; done = 1'b0; n = 0;
    while (!done && n < 200 && reset) begin
      @(negedge clock);
      s = lsu ? lsu_r_s2m : ifu_r_s2m;
      if (s.arready) got_ar = 1'b1;
      if (s.rvalid && s.rlast) done = 1'b1;
      @(posedge clock);
      #1;
      if (got_ar) begin
        if (lsu) lsu_r_m2s.arvalid = 1'b0; else ifu_r_m2s.arvalid = 1'b0;
      end
      n++;
    end
    if (lsu) lsu_r_m2s.arvalid = 1'b0; else ifu_r_m2s.arvalid = 1'b0;
    if (!done && reset) begin
      checks++; errors++;
      $display("FAIL rd_timeout: read of %h got no rlast in %0d cycles, required completion", addr, n);
    end
  endtask

  // LSU single-beat write: AW and W offered together, each dropped once accepted, wait for B.
  task automatic lsu_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic aw_ok, w_ok, done;
    int n;
    lsu_w_m2s = '0;
    lsu_w_m2s.awvalid = 1'b1; lsu_w_m2s.awaddr = addr; lsu_w_m2s.awsize = 3'b010;
    lsu_w_m2s.awburst = 2'b01; lsu_w_m2s.wvalid = 1'b1; lsu_w_m2s.wdata = data;
    lsu_w_m2s.wstrb = strb; lsu_w_m2s.wlast = 1'b1; lsu_w_m2s.bready = 1'b1;
    aw_ok = 1'b0; w_ok = 1'b0; done = 1'b0; n = 0;
    while (!done && n < 200 && reset) begin
      @(negedge clock);
      if (lsu_w_m2s.awvalid && lsu_w_s2m.awready) aw_ok = 1'b1;
      if (lsu_w_m2s.wvalid && lsu_w_s2m.wready) w_ok = 1'b1;
      if (lsu_w_s2m.bvalid) done = 1'b1;
      @(posedge clock);
      #1;
      if (aw_ok) lsu_w_m2s.awvalid = 1'b0;
      if (w_ok) lsu_w_m2s.wvalid = 1'b0;
      n++;
    end
    lsu_w_m2s.awvalid = 1'b0; lsu_w_m2s.wvalid = 1'b0;
    if (!done && reset) begin
      checks++; errors++;
      $display("FAIL wr_timeout: write to %h got no B in %0d cycles, required completion", addr, n);
    end
  endtask

  // Monitor: pops the scoreboard on every observed handshake and checks channel isolation.
  logic [1:0] prev_grant = 2'b00;
  int idle_cnt = 0;
  initial begin
    rbeat_t got, exp;
    wbeat_t wexp;
    logic ok;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_grant = 2'b00;
        idle_cnt = 0;
      end else begin
        if (arb_grant != 2'b00 && prev_grant == 2'b00) begin
          if (grant_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant_unexpected: got %0d, expected no grant", arb_grant);
          end else begin
            check_eq("grant_order", arb_grant, grant_q.pop_front());
          end
          last_gap = idle_cnt;
          idle_cnt = 0;
        end else if (arb_grant != 2'b00 && arb_grant != prev_grant) begin
          checks++; errors++;
          $display("FAIL grant_no_idle: got %0d straight after %0d, required an idle cycle", arb_grant, prev_grant);
        end
        if (arb_grant == 2'b00) idle_cnt++;
        prev_grant = arb_grant;

        if (ifu_r_s2m.rvalid && ifu_r_m2s.rready) begin
          got = '{ifu_r_s2m.rdata, ifu_r_s2m.rresp, ifu_r_s2m.rlast};
          ifu_beats++;
          if (ifu_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL ifu_unexpected_beat: got %h, expected none", got.data);
          end else begin
            exp = ifu_q.pop_front();
            check_eq("ifu_rbeat", got, exp);
          end
        end
        if (lsu_r_s2m.rvalid && lsu_r_m2s.rready) begin
          got = '{lsu_r_s2m.rdata, lsu_r_s2m.rresp, lsu_r_s2m.rlast};
          if (lsu_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL lsu_unexpected_beat: got %h, expected none", got.data);
          end else begin
            exp = lsu_q.pop_front();
            check_eq("lsu_rbeat", got, exp);
          end
        end
        if (mem_w_m2s.awvalid && mem_w_s2m.awready) begin
          if (aw_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL aw_unexpected: got %h, expected none", mem_w_m2s.awaddr);
          end else check_eq("mem_awaddr", mem_w_m2s.awaddr, aw_q.pop_front());
        end
        if (mem_w_m2s.wvalid && mem_w_s2m.wready) begin
          if (w_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_unexpected: got %h, expected none", mem_w_m2s.wdata);
          end else begin
            wexp = w_q.pop_front();
            check_eq("mem_wdata_strb", {mem_w_m2s.wdata, mem_w_m2s.wstrb}, wexp);
          end
        end
        if (lsu_w_s2m.bvalid && lsu_w_m2s.bready) begin
          if (b_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected: got %0h, expected none", lsu_w_s2m.bresp);
          end else check_eq("b_grant_resp", {arb_grant, lsu_w_s2m.bresp}, {2'b11, b_q.pop_front()});
        end

        ok = 1'b1;
        if (arb_grant != 2'b01 && (ifu_r_s2m.arready || ifu_r_s2m.rvalid)) ok = 1'b0;
        if (arb_grant != 2'b10 && (lsu_r_s2m.arready || lsu_r_s2m.rvalid)) ok = 1'b0;
        if (arb_grant != 2'b11 && (lsu_w_s2m.awready || lsu_w_s2m.wready || lsu_w_s2m.bvalid ||
                                   mem_w_m2s.awvalid || mem_w_m2s.wvalid)) ok = 1'b0;
        if ((arb_grant == 2'b00 || arb_grant == 2'b11) && mem_r_m2s.arvalid) ok = 1'b0;
        if (arb_busy != (arb_grant != 2'b00)) ok = 1'b0;
        check_eq("isolation", ok, 1'b1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b0; sel_fp = 1'b0;
    ifu_r_m2s = '0; lsu_r_m2s = '0; lsu_w_m2s = '0;
    repeat (3) @(negedge clock);
    check_eq("reset_outputs", vr_vec(), '0);
    idle(1);
    reset = 1'b1;
    @(negedge clock);
    check_eq("idle_after_reset", {arb_busy, arb_grant}, 3'b000);
    idle(1);

    // 1: lone IFU read, grant one cycle after arvalid
    grant_q.push_back(2'b01);
    ifu_q.push_back('{32'hDEADBEEF, 2'b00, 1'b1});
    fork
      rd_master(1'b0, 32'h3000_0000, 8'd0);
      begin
        @(negedge clock);
        check_eq("t1_grant_same_cycle", arb_grant, 2'b00);
        @(negedge clock);
        check_eq("t1_grant_next_cycle", arb_grant, 2'b01);
        check_eq("t1_lsu_ports_zero", {lsu_r_s2m, lsu_w_s2m}, '0);
      end
    join
    idle(2);

    // 2: simultaneous reads, round-robin: LSU first after reset, then IFU after one idle cycle
    grant_q.push_back(2'b10);
    grant_q.push_back(2'b01);
    lsu_q.push_back('{32'h8000_0010, 2'b01, 1'b1});
    ifu_q.push_back('{32'h3000_0004, 2'b00, 1'b1});
    fork
      rd_master(1'b1, 32'h8000_0010, 8'd0);
      rd_master(1'b0, 32'h3000_0004, 8'd0);
    join
    check_eq("t2_idle_gap", last_gap, 1);
    idle(2);

    // 4: LSU store with IFU read held throughout
    grant_q.push_back(2'b11);
    grant_q.push_back(2'b01);
    aw_q.push_back(32'h8000_0004);
    w_q.push_back('{32'h1234_5678, 4'b1111});
    b_q.push_back(2'b01);
    ifu_q.push_back('{32'h3000_0008, 2'b00, 1'b1});
    fork
      lsu_write(32'h8000_0004, 32'h1234_5678, 4'b1111);
      rd_master(1'b0, 32'h3000_0008, 8'd0);
    join
    idle(2);

    // 5: IFU 4-beat burst, LSU read pending behind it
    grant_q.push_back(2'b01);
    grant_q.push_back(2'b10);
    ifu_q.push_back('{32'h3000_0100, 2'b00, 1'b0});
    ifu_q.push_back('{32'h3000_0104, 2'b00, 1'b0});
    ifu_q.push_back('{32'h3000_0108, 2'b00, 1'b0});
    ifu_q.push_back('{32'h3000_010C, 2'b00, 1'b1});
    lsu_q.push_back('{32'h8000_0020, 2'b01, 1'b1});
    fork
      rd_master(1'b0, 32'h3000_0100, 8'd3);
      begin
        idle(1);
        rd_master(1'b1, 32'h8000_0020, 8'd0);
      end
    join
    idle(2);

    // 6: reset asserted during beat 3 of an IFU burst
    grant_q.push_back(2'b01);
    ifu_q.push_back('{32'h3000_0200, 2'b00, 1'b0});
    ifu_q.push_back('{32'h3000_0204, 2'b00, 1'b0});
    ifu_q.push_back('{32'h3000_0208, 2'b00, 1'b0});
    ifu_q.push_back('{32'h3000_020C, 2'b00, 1'b1});
    t6_base = ifu_beats;
    fork
      rd_master(1'b0, 32'h3000_0200, 8'd3);
      begin
        n = 0;
        while (ifu_beats < t6_base + 2 && n < 100) begin
          @(negedge clock);
          #1;
          n++;
        end
        check_eq("t6_beats_before_reset", ifu_beats - t6_base, 2);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_eq("t6_reset_outputs", vr_vec(), '0);
        ifu_q.delete();
        grant_q.delete();
      end
    join
    idle(2);
    reset = 1'b1;
    idle(1);
    grant_q.push_back(2'b01);
    ifu_q.push_back('{32'hDEADBEEF, 2'b00, 1'b1});
    rd_master(1'b0, 32'h3000_0000, 8'd0);
    idle(2);

    // 3: fixed priority, LSU re-requests back to back; IFU waits until the LSU stops
    reset = 1'b0;
    sel_fp = 1'b1;
    idle(2);
    reset = 1'b1;
    idle(1);
    grant_q.push_back(2'b10);
    grant_q.push_back(2'b10);
    grant_q.push_back(2'b10);
    grant_q.push_back(2'b01);
    lsu_q.push_back('{32'h8000_0030, 2'b01, 1'b1});
    lsu_q.push_back('{32'h8000_0034, 2'b01, 1'b1});
    lsu_q.push_back('{32'h8000_0038, 2'b01, 1'b1});
    ifu_q.push_back('{32'h3000_000C, 2'b00, 1'b1});
    fork
      rd_master(1'b0, 32'h3000_000C, 8'd0);
      begin
        rd_master(1'b1, 32'h8000_0030, 8'd0);
        rd_master(1'b1, 32'h8000_0034, 8'd0);
        rd_master(1'b1, 32'h8000_0038, 8'd0);
      end
    join
    idle(3);

    check_eq("scoreboard_drained",
             grant_q.size() + ifu_q.size() + lsu_q.size() + aw_q.size() + w_q.size() + b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
